// File: rtl/ififo_skew_bank_if.sv
// Handshake/data bundle between the activation producer and the west-edge FIFO bank.
// The master side pushes vectors and requests read waves; the slave side is the FIFO bank.
interface ififo_skew_bank_if #(
    parameter int ROW = 8,
    parameter int BW  = 4
);
    logic [ROW*BW-1:0] in;
    logic              wr;
    logic              rd;
    logic              i_mode;
    logic [ROW*BW-1:0] out;
    logic [ROW-1:0]    o_valid;
    logic              o_full;
    logic              o_ready;
    logic              o_empty;
    logic              o_busy;
    logic              o_err;

    modport master (
        output in, wr, rd, i_mode,
        input  out, o_valid, o_full, o_ready, o_empty, o_busy, o_err
    );

    modport slave (
        input  in, wr, rd, i_mode,
        output out, o_valid, o_full, o_ready, o_empty, o_busy, o_err
    );
endinterface

// File: rtl/ififo_skew_bank.sv
// Input-activation FIFO bank: ROW lanes x DEPTH entries, popped together (broadcast)
// or as a one-cycle-per-lane staggered wave (skew) into the systolic array west edge.
module ififo_skew_bank #(
    parameter int ROW   = 8,
    parameter int BW    = 4,
    parameter int DEPTH = 64
) (
    input logic               clk,
    input logic               reset,
    ififo_skew_bank_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BW-1:0] mem_q [ROW][DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q [ROW];
    logic [AW-1:0] rd_ptr_d [ROW];
    logic [CW-1:0] count_q  [ROW];
    logic [CW-1:0] count_d  [ROW];
    logic [BW-1:0] out_q    [ROW];
    logic [BW-1:0] out_d    [ROW];
    logic [ROW-1:0] sr_q, sr_d;
    logic full_q, full_d;
    logic empty_q, empty_d;
    logic err_q, err_d;
    logic mode_q, mode_d;
    logic wr_acc, go;

    // Lane i pops on the edge that sets sr[i], so o_valid[i] and the new data land together.
    always_comb begin
        wr_acc = bus.wr & ~full_q;
        go     = bus.rd & ~empty_q;

        sr_d[0] = go;
        for (int i = 1; i < ROW; i++) begin
            sr_d[i] = mode_q ? sr_q[i-1] : go;
        end

        wr_ptr_d = wr_ptr_q + AW'(wr_acc);
        full_d   = 1'b0;
        for (int i = 0; i < ROW; i++) begin
            rd_ptr_d[i] = rd_ptr_q[i] + AW'(sr_d[i]);
            out_d[i]    = sr_d[i] ? mem_q[i][rd_ptr_q[i]] : out_q[i];
            count_d[i]  = count_q[i] + CW'(wr_acc) - CW'(sr_d[i]);
            full_d      = full_d | (count_d[i] == CW'(DEPTH));
        end
        empty_d = (count_d[0] == '0);

        err_d  = err_q | (bus.wr & full_q) | (bus.rd & empty_q);
        // A pending mode change waits until no wave is in flight or starting.
        mode_d = (~(|sr_q) & ~go) ? bus.i_mode : mode_q;
    end

    // NOTE: storage array has no reset; reset clears the pointers and counts, which discards its contents logically.
    always_ff @(posedge clk) begin
        if (wr_acc && !reset) begin
            for (int i = 0; i < ROW; i++) begin
                mem_q[i][wr_ptr_q] <= bus.in[i*BW +: BW];
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            sr_q     <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            err_q    <= 1'b0;
            mode_q   <= 1'b1;
            for (int i = 0; i < ROW; i++) begin
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
                out_q[i]    <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            sr_q     <= sr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            err_q    <= err_d;
            mode_q   <= mode_d;
            for (int i = 0; i < ROW; i++) begin
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
                out_q[i]    <= out_d[i];
            end
        end
    end

    always_comb begin
        bus.out = '0;
        for (int i = 0; i < ROW; i++) begin
            bus.out[i*BW +: BW] = out_q[i];
        end
    end

    assign bus.o_valid = sr_q;
    assign bus.o_full  = full_q;
    assign bus.o_ready = ~full_q;
    assign bus.o_empty = empty_q;
    assign bus.o_busy  = |sr_q;
    assign bus.o_err   = err_q;
endmodule

// File: tb/tb_ififo_skew_bank.sv
// Randomised and directed stimulus for ififo_skew_bank, checked every cycle against a
// queue-based model that schedules each lane's pop time from the read-wave rules.
module tb_ififo_skew_bank;
    localparam int ROW   = 8;
    localparam int BW    = 4;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ififo_skew_bank_if #(.ROW(ROW), .BW(BW)) bus ();

    ififo_skew_bank #(.ROW(ROW), .BW(BW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: per-lane data queues plus per-lane queues of scheduled pop cycles.
    typedef logic [BW-1:0] lane_q_t[$];
    typedef int            due_q_t[$];
    lane_q_t        mq  [ROW];
    due_q_t         due [ROW];
    int             cyc = 0;
    bit             m_mode = 1'b1;
    bit             m_err  = 1'b0;
    logic [ROW-1:0] m_valid = '0;
    logic [BW-1:0]  m_out [ROW];

    function automatic logic [ROW*BW-1:0] pack_out();
        logic [ROW*BW-1:0] v;
        for (int i = 0; i < ROW; i++) v[i*BW +: BW] = m_out[i];
        return v;
    endfunction

    function automatic bit m_full();
        bit f = 1'b0;
        for (int i = 0; i < ROW; i++) if (mq[i].size() == DEPTH) f = 1'b1;
        return f;
    endfunction

    task automatic model_step();
        bit full, empty, wr_acc, go, busy_now;
        if (reset) begin
            for (int i = 0; i < ROW; i++) begin
                mq[i].delete();
                due[i].delete();
                m_out[i] = '0;
            end
            m_mode  = 1'b1;
            m_err   = 1'b0;
            m_valid = '0;
        end else begin
            full     = m_full();
            empty    = (mq[0].size() == 0);
            wr_acc   = bus.wr && !full;
            go       = bus.rd && !empty;
            busy_now = |m_valid;
            if ((bus.wr && full) || (bus.rd && empty)) m_err = 1'b1;
            if (go) for (int i = 0; i < ROW; i++) due[i].push_back(cyc + (m_mode ? i : 0));
            m_valid = '0;
            for (int i = 0; i < ROW; i++) begin
                if (due[i].size() > 0 && due[i][0] == cyc) begin
                    void'(due[i].pop_front());
                    m_out[i]   = mq[i].pop_front();
                    m_valid[i] = 1'b1;
                end
            end
            if (wr_acc) for (int i = 0; i < ROW; i++) mq[i].push_back(bus.in[i*BW +: BW]);
            if (!busy_now && !go) m_mode = bus.i_mode;
        end
        cyc++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("out",     64'(bus.out),     64'(pack_out()));
        check("o_valid", 64'(bus.o_valid), 64'(m_valid));
        check("o_full",  64'(bus.o_full),  64'(m_full()));
        check("o_ready", 64'(bus.o_ready), 64'(!m_full()));
        check("o_empty", 64'(bus.o_empty), 64'(mq[0].size() == 0));
        check("o_busy",  64'(bus.o_busy),  64'(|m_valid));
        check("o_err",   64'(bus.o_err),   64'(m_err));
    endtask

    task automatic drive(input bit w, input bit r, input logic [31:0] d, input bit m);
        bus.wr     = w;
        bus.rd     = r;
        bus.in     = d;
        bus.i_mode = m;
        tick();
    endtask

    task automatic idle(input int n, input bit m);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 32'h0, m);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 32'h0, 1'b1);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < ROW; i++) m_out[i] = '0;
        reset      = 1'b1;
        bus.wr     = 1'b0;
        bus.rd     = 1'b0;
        bus.in     = '0;
        bus.i_mode = 1'b1;
        #2;

        // Reset state
        do_reset(2);
        check("reset_ready", 64'(bus.o_ready), 64'd1);
        check("reset_empty", 64'(bus.o_empty), 64'd1);

        // Broadcast: three vectors then three reads
        idle(1, 1'b0);
        drive(1'b1, 1'b0, 32'h76543210, 1'b0);
        drive(1'b1, 1'b0, 32'hFEDCBA98, 1'b0);
        drive(1'b1, 1'b0, 32'h01234567, 1'b0);
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        check("bc_valid0", 64'(bus.o_valid), 64'hFF);
        check("bc_out0",   64'(bus.out),     64'h76543210);
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        check("bc_out2",   64'(bus.out),     64'h01234567);
        check("bc_empty",  64'(bus.o_empty), 64'd1);
        idle(3, 1'b0);

        // Skew: one wave, lane i valid at t+1+i
        do_reset(1);
        drive(1'b1, 1'b0, 32'h76543210, 1'b1);
        drive(1'b0, 1'b1, 32'h0, 1'b1);
        for (int i = 0; i < ROW; i++) begin
            check("sk_valid", 64'(bus.o_valid), 64'(8'(1) << i));
            check("sk_lane",  64'(bus.out[i*BW +: BW]), 64'(i));
            idle(1, 1'b1);
        end
        check("sk_idle", 64'(bus.o_busy), 64'd0);

        // Fill to full, overflow write, drain back-to-back
        do_reset(1);
        for (int k = 0; k < DEPTH; k++) drive(1'b1, 1'b0, $urandom, 1'b1);
        check("full_set", 64'(bus.o_full), 64'd1);
        drive(1'b1, 1'b0, 32'hA5A5A5A5, 1'b1);
        check("ovf_err", 64'(bus.o_err), 64'd1);
        for (int k = 0; k < DEPTH; k++) drive(1'b0, 1'b1, 32'h0, 1'b1);
        idle(ROW + 2, 1'b1);

        // Read while empty
        do_reset(1);
        drive(1'b0, 1'b1, 32'h0, 1'b1);
        check("empty_rd_err", 64'(bus.o_err), 64'd1);
        idle(2, 1'b1);

        // Mode change requested mid skew wave is deferred
        do_reset(1);
        drive(1'b1, 1'b0, 32'h89ABCDEF, 1'b1);
        drive(1'b1, 1'b0, 32'h13572468, 1'b1);
        drive(1'b0, 1'b1, 32'h0, 1'b1);
        for (int k = 0; k < ROW + 1; k++) idle(1, 1'b0);
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        check("defer_bc", 64'(bus.o_valid), 64'hFF);
        idle(2, 1'b0);

        // Reset during a skew wave
        do_reset(1);
        drive(1'b1, 1'b0, 32'h76543210, 1'b1);
        drive(1'b1, 1'b0, 32'h12345678, 1'b1);
        drive(1'b0, 1'b1, 32'h0, 1'b1);
        idle(2, 1'b1);
        do_reset(1);
        check("rst_mid_busy", 64'(bus.o_busy), 64'd0);
        drive(1'b0, 1'b1, 32'h0, 1'b1);
        idle(ROW, 1'b1);

        // Random traffic
        do_reset(1);
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(1);
            end else begin
                drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), $urandom,
                      ($urandom_range(0, 19) == 0) ? ~bus.i_mode : bus.i_mode);
            end
        end
        idle(ROW + 2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
